// File: rtl/test_runner.sv
// test_runner: runs each method channel in turn (request, wait for busy to
// rise and fall, compare its return against the expected value) and reports
// per-channel failures, a sticky timeout flag and an overall verdict.
module test_runner #(
  parameter int NUM_TESTS   = 4,
  parameter int RET_WIDTH   = 32,
  parameter int START_DELAY = 100,
  parameter int TIMEOUT     = 10000
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [NUM_TESTS-1:0]           test_req,
  input  logic [NUM_TESTS-1:0]           test_busy,
  input  logic [NUM_TESTS*RET_WIDTH-1:0] test_return,
  input  logic [NUM_TESTS*RET_WIDTH-1:0] test_expected,
  output logic [7:0]                     cur_index,
  output logic [NUM_TESTS-1:0]           fail_vec,
  output logic                           timeout,
  output logic                           done,
  output logic                           pass
);

  typedef enum logic [2:0] {
    WAIT_START,
    REQ,
    RUN,
    CHECK,
    NEXT,
    DONE
  } state_t;

  localparam logic [31:0] DELAY_LAST = (START_DELAY > 0) ? 32'(START_DELAY - 1) : '0;
  localparam logic [31:0] TO_LIMIT   = 32'(TIMEOUT);
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_TESTS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          delay_cnt;
  logic [31:0]          to_cnt;
  logic [31:0]          to_inc;
  logic                 to_hit;
  logic [NUM_TESTS-1:0] cur_onehot;
  logic [NUM_TESTS-1:0] mism;
  logic                 cur_busy;
  logic                 active;

  // Channel selection as a one-hot mask, so no variable index can run past
  // the vector once cur_index steps beyond the last channel.
  always_comb begin
    cur_onehot = '0;
    mism       = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      cur_onehot[i] = (cur_index == 8'(i));
      mism[i]       = (test_return[i*RET_WIDTH +: RET_WIDTH] !=
                       test_expected[i*RET_WIDTH +: RET_WIDTH]);
    end
    cur_busy = |(test_busy & cur_onehot);
  end

  // Saturating increment of the per-channel timeout counter and its limit test.
  always_comb begin
    to_inc = (to_cnt == '1) ? to_cnt : to_cnt + 32'd1;
    to_hit = (to_inc >= TO_LIMIT);
    active = (state == REQ) || (state == RUN);
  end

  // Next-state logic; a timeout takes priority over the busy handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_START: begin
        if ((START_DELAY == 0) || (delay_cnt == DELAY_LAST)) state_nxt = REQ;
      end
      REQ: begin
        if (to_hit)        state_nxt = NEXT;
        else if (cur_busy) state_nxt = RUN;
      end
      RUN: begin
        if (to_hit)         state_nxt = NEXT;
        else if (!cur_busy) state_nxt = CHECK;
      end
      CHECK: state_nxt = NEXT;
      NEXT: begin
        if (cur_index == LAST_IDX) state_nxt = DONE;
        else                       state_nxt = REQ;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = WAIT_START;
    endcase
  end

  // Outputs decoded from the registered state, so reset clears them at once.
  always_comb begin
    test_req = (state == REQ) ? cur_onehot : '0;
    done     = (state == DONE);
    pass     = done && (fail_vec == '0) && !timeout;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_START;
    else        state <= state_nxt;
  end

  // Start-up delay counter, running only while waiting to start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   delay_cnt <= '0;
    else if (state == WAIT_START) delay_cnt <= delay_cnt + 32'd1;
  end

  // Timeout counter: cleared on entry to REQ, counts through REQ and RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    to_cnt <= '0;
    else if ((state != REQ) && (state_nxt == REQ)) to_cnt <= '0;
    else if (active)                               to_cnt <= to_inc;
  end

  // Channel pointer advances once per channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cur_index <= '0;
    else if (state == NEXT) cur_index <= cur_index + 8'd1;
  end

  // Sticky failure and timeout flags; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_vec <= '0;
      timeout  <= 1'b0;
    end else if (active && to_hit) begin
      fail_vec <= fail_vec | cur_onehot;
      timeout  <= 1'b1;
    end else if (state == CHECK) begin
      fail_vec <= fail_vec | (cur_onehot & mism);
    end
  end

endmodule

// File: tb/tb_test_runner.sv
// tb_test_runner: drives randomized method channels into test_runner and
// checks every cycle against a schedule computed from the channel plans.
module tb_test_runner;

  localparam int NT = 4;
  localparam int RW = 32;
  localparam int SD = 100;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // single-channel, 1-bit instance
  logic [0:0] req_a, busy_a, ret_a, exp_a, fail_a;
  logic [7:0] idx_a;
  logic       to_a, done_a, pass_a;

  test_runner #(.NUM_TESTS(1), .RET_WIDTH(1), .START_DELAY(SD)) dut_a (
    .clk(clk), .reset(reset), .test_req(req_a), .test_busy(busy_a),
    .test_return(ret_a), .test_expected(exp_a), .cur_index(idx_a),
    .fail_vec(fail_a), .timeout(to_a), .done(done_a), .pass(pass_a)
  );

  // four-channel, 32-bit instance
  logic [NT-1:0]    req_b, busy_b, fail_b;
  logic [NT*RW-1:0] ret_b, exp_b;
  logic [7:0]       idx_b;
  logic             to_b, done_b, pass_b;

  test_runner #(.NUM_TESTS(NT), .RET_WIDTH(RW), .START_DELAY(SD), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .test_req(req_b), .test_busy(busy_b),
    .test_return(ret_b), .test_expected(exp_b), .cur_index(idx_b),
    .fail_vec(fail_b), .timeout(to_b), .done(done_b), .pass(pass_b)
  );

  // channel plans: mode 0 = busy after dd cycles for bb cycles,
  // 1 = busy already high, drops bb cycles after request, 2 = never busy
  int          mode [NT];
  int          dd   [NT];
  int          bb   [NT];
  logic [31:0] retv [NT];
  logic [31:0] expv [NT];

  // expected schedule, in clock edges counted from reset release (first = 1)
  int st [NT];
  int rl [NT];
  int nx [NT];
  int ft [NT];
  bit fl [NT];
  bit tmo_exp;
  int tmo_t;
  int done_t;

  int n;
  bit chk_en;
  int scen;
  int started [NT];
  int tt [NT];
  bit sa;
  int ta;
  logic [NT-1:0] req_seen;
  int req1_len;
  int req_hi_total;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expct);
    n_vec++;
    if (act !== expct) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, scenario %0d)", name, act, expct, n, scen);
    end
  endtask

  // schedule from the plans: a channel's turn lasts execution + 3 cycles,
  // or TIMEOUT + 1 cycles when busy never shows
  function automatic void build_model();
    int s;
    s       = SD;
    tmo_exp = 1'b0;
    tmo_t   = 0;
    for (int i = 0; i < NT; i++) begin
      st[i] = s;
      if (mode[i] == 2) begin
        rl[i] = TO;
        fl[i] = 1'b1;
        ft[i] = s + TO;
        nx[i] = s + TO + 1;
        if (!tmo_exp) tmo_t = s + TO;
        tmo_exp = 1'b1;
      end else begin
        rl[i] = dd[i] + 1;
        fl[i] = (retv[i] != expv[i]);
        ft[i] = s + dd[i] + bb[i] + 2;
        nx[i] = s + dd[i] + bb[i] + 3;
      end
      s = nx[i];
    end
    done_t = s;
  endfunction

  task automatic compare_b();
    logic [NT-1:0] er;
    logic [NT-1:0] ef;
    logic          eto;
    logic          edn;
    logic          eps;
    int            ei;
    er = '0;
    ef = '0;
    ei = 0;
    for (int i = 0; i < NT; i++) begin
      if (n >= st[i] && n < st[i] + rl[i]) er[i] = 1'b1;
      if (fl[i] && n >= ft[i])             ef[i] = 1'b1;
      if (n >= st[i] && n < nx[i])         ei = i;
    end
    eto = tmo_exp && (n >= tmo_t);
    edn = (n >= done_t);
    eps = edn && (ef == '0) && !eto;
    chk("test_req", 32'(req_b), 32'(er));
    chk("fail_vec", 32'(fail_b), 32'(ef));
    chk("timeout", 32'(to_b), 32'(eto));
    chk("done", 32'(done_b), 32'(edn));
    chk("pass", 32'(pass_b), 32'(eps));
    if (!edn) chk("cur_index", 32'(idx_b), 32'(ei));
  endtask

  // channel models: react to the request seen after each edge
  task automatic drive();
    bit fin;
    for (int i = 0; i < NT; i++) begin
      if (reset) begin
        if (started[i] != 0) tt[i]++;
        else if (req_b[i]) begin
          started[i] = 1;
          tt[i]      = 0;
        end
      end
      fin = 1'b0;
      case (mode[i])
        0: begin
          busy_b[i] = (started[i] != 0) && tt[i] >= dd[i] && tt[i] < dd[i] + bb[i];
          fin       = (started[i] != 0) && tt[i] >= dd[i] + bb[i];
        end
        1: begin
          busy_b[i] = (started[i] == 0) || tt[i] < bb[i];
          fin       = (started[i] != 0) && tt[i] >= bb[i];
        end
        default: busy_b[i] = 1'b0;
      endcase
      ret_b[i*RW +: RW] = fin ? retv[i] : 32'($urandom);
      exp_b[i*RW +: RW] = expv[i];
    end
    if (reset) begin
      if (sa) ta++;
      else if (req_a[0]) begin
        sa = 1'b1;
        ta = 0;
      end
    end
    busy_a[0] = sa && (ta < 5);
    ret_a[0]  = 1'b1;
    exp_a[0]  = 1'b1;
  endtask

  // per-cycle compare and stimulus process
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        n  = 0;
        sa = 1'b0;
        ta = 0;
        for (int i = 0; i < NT; i++) begin
          started[i] = 0;
          tt[i]      = 0;
        end
      end else begin
        n++;
        if (chk_en) compare_b();
        if (scen == 0) begin
          if (n == 99)  chk("a_req_before", 32'(req_a), 32'h0);
          if (n == 100) chk("a_req_rise", 32'(req_a), 32'h1);
          if (n == 101) chk("a_req_one_cycle", 32'(req_a), 32'h0);
          if (n == 107) chk("a_done_early", 32'(done_a), 32'h0);
          if (n == 108) begin
            chk("a_done", 32'(done_a), 32'h1);
            chk("a_pass", 32'(pass_a), 32'h1);
            chk("a_fail_vec", 32'(fail_a), 32'h0);
            chk("a_timeout", 32'(to_a), 32'h0);
          end
        end
        req_seen = req_seen | req_b;
        if (req_b[1]) req1_len++;
        req_hi_total += $countones(req_b);
      end
      drive();
    end
  end

  task automatic random_plan();
    for (int i = 0; i < NT; i++) begin
      int r;
      r       = int'($urandom_range(0, 9));
      mode[i] = (r < 6) ? 0 : (r < 9) ? 1 : 2;
      dd[i]   = (mode[i] == 0) ? int'($urandom_range(0, 3)) : 0;
      bb[i]   = int'($urandom_range(1, 15));
      retv[i] = $urandom;
      expv[i] = ($urandom_range(0, 3) == 0) ? (retv[i] ^ (32'h1 << $urandom_range(0, 31))) : retv[i];
    end
  endtask

  task automatic clean_plan();
    for (int i = 0; i < NT; i++) begin
      mode[i] = 0;
      dd[i]   = int'($urandom_range(0, 3));
      bb[i]   = int'($urandom_range(1, 12));
      retv[i] = $urandom;
      expv[i] = retv[i];
    end
  endtask

  task automatic start_scn();
    reset = 1'b0;
    build_model();
    req_seen     = '0;
    req1_len     = 0;
    req_hi_total = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic run_scn();
    start_scn();
    repeat (done_t + 4) @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    chk_en       = 1'b0;
    scen         = -1;
    n            = 0;
    sa           = 1'b0;
    ta           = 0;
    req_seen     = '0;
    req1_len     = 0;
    req_hi_total = 0;
    for (int i = 0; i < NT; i++) begin
      started[i] = 0;
      tt[i]      = 0;
    end
    clean_plan();
    drive();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", 32'(req_b), 32'h0);
    chk("rst_idx", 32'(idx_b), 32'h0);
    chk("rst_fail", 32'(fail_b), 32'h0);
    chk("rst_timeout", 32'(to_b), 32'h0);
    chk("rst_done", 32'(done_b), 32'h0);
    chk("rst_pass", 32'(pass_b), 32'h0);

    // channel 2 returns a wrong value
    scen = 0;
    clean_plan();
    retv[2] = 32'hffff_fffe;
    expv[2] = 32'hffff_fffd;
    run_scn();
    chk("s0_fail_vec", 32'(fail_b), 32'h4);
    chk("s0_timeout", 32'(to_b), 32'h0);
    chk("s0_pass", 32'(pass_b), 32'h0);
    chk("s0_done", 32'(done_b), 32'h1);
    chk("s0_all_run", 32'(req_seen), 32'hf);

    // channel 1 never goes busy
    scen = 1;
    clean_plan();
    mode[1] = 2;
    run_scn();
    chk("s1_fail_vec", 32'(fail_b), 32'h2);
    chk("s1_timeout", 32'(to_b), 32'h1);
    chk("s1_all_run", 32'(req_seen), 32'hf);
    chk("s1_req1_len", 32'(req1_len), 32'd50);
    chk("s1_pass", 32'(pass_b), 32'h0);

    // busy already high at request time on every channel
    scen = 2;
    clean_plan();
    for (int i = 0; i < NT; i++) begin
      mode[i] = 1;
      dd[i]   = 0;
    end
    run_scn();
    chk("s2_req_cycles", 32'(req_hi_total), 32'd4);
    chk("s2_pass", 32'(pass_b), 32'h1);
    chk("s2_fail_vec", 32'(fail_b), 32'h0);

    // return differs from expected only in the MSB
    scen = 3;
    clean_plan();
    expv[0] = 32'h1234_5678;
    retv[0] = 32'h9234_5678;
    run_scn();
    chk("s3_fail_vec", 32'(fail_b), 32'h1);
    chk("s3_pass", 32'(pass_b), 32'h0);

    // reset while channel 2 is running, then a clean rerun
    scen = 4;
    clean_plan();
    retv[1] = expv[1] ^ 32'h10;
    bb[2]   = 6;
    start_scn();
    repeat (st[2] + rl[2] + 1) @(posedge clk);
    #2;
    chk("s4_pre_fail", 32'(fail_b), 32'h2);
    chk("s4_pre_idx", 32'(idx_b), 32'h2);
    reset = 1'b0;
    #1;
    chk("s4_req_clear", 32'(req_b), 32'h0);
    chk("s4_fail_clear", 32'(fail_b), 32'h0);
    chk("s4_timeout_clear", 32'(to_b), 32'h0);
    chk("s4_done_clear", 32'(done_b), 32'h0);
    chk("s4_idx_clear", 32'(idx_b), 32'h0);
    clean_plan();
    run_scn();
    chk("s4_rerun_pass", 32'(pass_b), 32'h1);
    chk("s4_rerun_done", 32'(done_b), 32'h1);

    // randomized mixes
    for (int k = 0; k < 8; k++) begin
      scen = 5 + k;
      random_plan();
      run_scn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_runner.md
TEST_RUNNER -- requirements
Module: test_runner

Interface
REQ-001 The block SHALL have parameter NUM_TESTS, default 4, meaning the number of method channels under test (legal 1..8).
REQ-002 The block SHALL have parameter RET_WIDTH, default 32, meaning the width of each channel's return value (legal 1..32).
REQ-003 The block SHALL have parameter START_DELAY, default 100, meaning the idle cycles after reset release before the first request.
REQ-004 The block SHALL have parameter TIMEOUT, default 10000, meaning the maximum cycles allowed per channel, counted from request assertion.
REQ-005 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset  input  1  meaning the asynchronous, active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port test_req  output  NUM_TESTS  meaning the per-channel method request; bit i drives channel i.
REQ-008 The block SHALL have port test_busy  input  NUM_TESTS  meaning the per-channel method busy.
REQ-009 The block SHALL have port test_return  input  NUM_TESTS*RET_WIDTH  meaning the returns, with channel i at bits [i*RET_WIDTH +: RET_WIDTH].
REQ-010 The block SHALL have port test_expected  input  NUM_TESTS*RET_WIDTH  meaning the expected returns, packed like test_return.
REQ-011 The block SHALL have port cur_index  output  8  meaning the channel currently under test.
REQ-012 The block SHALL have port fail_vec  output  NUM_TESTS  meaning the sticky per-channel failure flags.
REQ-013 The block SHALL have port timeout  output  1  meaning a sticky flag set when any channel times out.
REQ-014 The block SHALL have port done  output  1  meaning all channels have been run.
REQ-015 The block SHALL have port pass  output  1  meaning the overall verdict, valid only while done=1.

Function
REQ-016 The block SHALL implement the states WAIT_START, REQ, RUN, CHECK, NEXT and DONE.
REQ-017 WAIT_START SHALL count START_DELAY cycles after reset release, then enter REQ with cur_index=0.
REQ-018 In REQ the block SHALL hold test_req[cur_index]=1, with all other test_req bits 0, until the first cycle test_busy[cur_index]=1 is sampled; it SHALL then drop test_req and enter RUN.
REQ-019 In RUN the block SHALL wait for test_busy[cur_index]=0, then enter CHECK.
REQ-020 In CHECK, on the following cycle, the block SHALL compare the channel's test_return slice with its test_expected slice over all RET_WIDTH bits, unsigned and exact, and set fail_vec[cur_index] on mismatch.
REQ-021 Each channel SHALL have a 32-bit timeout counter, cleared on entry to REQ and incremented every cycle in REQ and RUN.
REQ-022 When the timeout counter reaches TIMEOUT, the block SHALL drop test_req, set fail_vec[cur_index] and timeout, skip CHECK and go to NEXT.
REQ-023 The timeout counter SHALL saturate rather than wrap.
REQ-024 If busy is already 1 on the cycle test_req first asserts, REQ SHALL last exactly one cycle.
REQ-025 If busy rises and falls between two samples, the channel SHALL be treated as timed out; no glitch detection is provided.
REQ-026 NEXT SHALL increment cur_index; if cur_index was NUM_TESTS-1, the block SHALL go to DONE, otherwise to REQ.
REQ-027 From request to next request, the latency per channel SHALL be exactly method-execution cycles + 3.
REQ-028 In DONE the block SHALL hold done=1 and pass=(fail_vec==0 && timeout==0), and remain there until reset.
REQ-029 test_return and test_expected SHALL be ignored outside CHECK.
REQ-030 fail_vec and timeout SHALL only be set, never cleared, except by reset.
REQ-031 pass SHALL be 0 whenever done=0.

Reset
REQ-032 While reset=0, test_req, cur_index, fail_vec, timeout, done and pass SHALL all be 0, and the state SHALL be WAIT_START with the delay counter at 0.
REQ-033 Reset asserted mid-run SHALL drop test_req asynchronously and discard all progress.
REQ-034 After reset is released, the sequence SHALL restart from WAIT_START.
REQ-035 Reset release SHALL be sampled on the first clk edge with reset=1.

Verification
REQ-036 The bench SHALL drive NUM_TESTS=1, RET_WIDTH=1, expected=1 with a model returning 1 after 5 busy cycles -> test_req rises at cycle 100 after release; done=1, pass=1, fail_vec=0.
REQ-037 The bench SHALL drive NUM_TESTS=4, RET_WIDTH=32, with channel 2 returning 32'hfffffffe against expected 32'hfffffffd -> fail_vec=4'b0100, timeout=0, pass=0, and channel 3 still run.
REQ-038 The bench SHALL hold test_busy[1]=0 permanently with TIMEOUT=50 -> test_req[1] drops after 50 cycles, fail_vec[1]=1, timeout=1, and channels 2 and 3 still run.
REQ-039 The bench SHALL hold busy already high at request time on every channel -> each REQ lasts 1 cycle and all channels pass.
REQ-040 The bench SHALL assert reset=0 while channel 2 is in RUN -> test_req and all flags clear immediately; after release the run restarts from channel 0 after START_DELAY and passes.
REQ-041 The bench SHALL check the boundary case where test_return equals expected except in its MSB, with RET_WIDTH=32 -> that channel fails.
